// File: rtl/spi_slave_wb.sv
// SPI mode-0 slave with a one-byte RX and a one-byte TX buffer behind a byte-wide bus port.
// SPI pins are oversampled and edge-detected in the clk domain; sclk must not exceed clk/8.
module spi_slave_wb #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wb_cyc,
    input  logic       i_wb_we,
    input  logic       i_wb_adr,
    input  logic [7:0] i_wb_dat,
    output logic [7:0] o_wb_dat,
    output logic       o_wb_ack,
    output logic       o_int,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 3;

    typedef enum logic {ST_IDLE, ST_FRAME} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_h, cs_h;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   cs_fall, sclk_rise, sclk_fall, in_frame;
    logic                   bit_rise, byte_done, tx_load, tx_step;

    logic [CW-1:0] bit_cnt;
    logic [DW-2:0] rx_shift;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] tx_shift;
    logic [DW-1:0] tx_buf;
    logic [DW-1:0] load_val;
    logic [DW-1:0] status;
    logic          rx_valid, tx_valid, overrun, int_en;
    logic          ack_cyc, rd_data, wr_data, wr_ctrl;

    // Pin synchronisers. cs_n resets low so a host still holding cs_n low
    // through reset does not look like a fresh frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_h    <= 1'b0;
            cs_h      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
            sclk_h    <= sclk_s;
            cs_h      <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_h & ~cs_s;
    assign sclk_rise = ~sclk_h & sclk_s;
    assign sclk_fall = sclk_h & ~sclk_s;

    // Frame tracking: a frame exists only after an observed cs_n falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_FRAME;
            ST_FRAME: if (cs_s)    state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign in_frame  = (state == ST_FRAME) & ~cs_s;
    assign bit_rise  = in_frame & sclk_rise;
    assign byte_done = bit_rise & (bit_cnt == CW'(DW - 1));
    assign tx_load   = cs_fall | (in_frame & sclk_fall & (bit_cnt == '0));
    assign tx_step   = in_frame & sclk_fall & (bit_cnt != '0);
    assign load_val  = tx_valid ? tx_buf : TX_IDLE;

    // Bus decode; side effects happen only in the ack cycle.
    assign ack_cyc = o_wb_ack & i_wb_cyc;
    assign rd_data = ack_cyc & ~i_wb_we & ~i_wb_adr;
    assign wr_data = ack_cyc & i_wb_we & ~i_wb_adr;
    assign wr_ctrl = ack_cyc & i_wb_we & i_wb_adr;
    assign status  = {5'b0, overrun, tx_valid, rx_valid};

    // Receive shifter and bit counter; leaving the frame discards a partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
        end else begin
            if (!in_frame) begin
                bit_cnt <= '0;
            end else if (bit_rise) begin
                bit_cnt <= bit_cnt + CW'(1);
            end
            if (bit_rise) begin
                rx_shift <= {rx_shift[DW-3:0], mosi_s};
            end
            if (byte_done) begin
                rx_data <= {rx_shift, mosi_s};
            end
        end
    end

    // Status flags; a new byte wins over a clearing read in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            int_en   <= 1'b1;
        end else begin
            if (byte_done) begin
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (byte_done && rx_valid && !rd_data) begin
                overrun <= 1'b1;
            end else if (wr_ctrl && i_wb_dat[0]) begin
                overrun <= 1'b0;
            end
            if (wr_ctrl) begin
                int_en <= i_wb_dat[1];
            end
        end
    end

    // Transmit side; a bus write racing a boundary load stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
            tx_buf   <= '0;
            tx_valid <= 1'b0;
            o_miso   <= 1'b0;
        end else begin
            if (tx_load) begin
                tx_shift <= load_val;
                o_miso   <= load_val[DW-1];
            end else if (tx_step) begin
                tx_shift <= {tx_shift[DW-2:0], 1'b0};
                o_miso   <= tx_shift[DW-2];
            end else if (!in_frame) begin
                o_miso   <= 1'b0;
            end
            if (wr_data) begin
                tx_buf   <= i_wb_dat;
                tx_valid <= 1'b1;
            end else if (tx_load) begin
                tx_valid <= 1'b0;
            end
        end
    end

    // Bus handshake: one-cycle ack, read data captured as ack is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_wb_ack <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            o_wb_ack <= i_wb_cyc & ~o_wb_ack;
            if (i_wb_cyc && !o_wb_ack) begin
                o_wb_dat <= i_wb_adr ? status : rx_data;
            end
        end
    end

    assign o_int = rx_valid & int_en;

endmodule
